// File: rtl/mips_muldiv_unit.sv
// MIPS execute-stage multiply/divide unit owning HI/LO; restoring divider at 1 bit/cycle.
// Optional MULDIV_ITER_MUL_EN: iterative shift-add multiply through the same FSM instead of a single-cycle product.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_SIGN
`ifdef MULDIV_ITER_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;   // divisor magnitude, or multiplicand magnitude
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sq, sr;

  logic             is_div, is_mul, b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             take;

  assign is_div = (op[2:1] == 2'b01);
  assign is_mul = (op[2:1] == 2'b00);
  assign b_zero = (b == '0);
  // MULTU/DIVU have op[0]=1 and are treated as non-negative
  assign a_neg  = ~op[0] & a[WIDTH-1];
  assign b_neg  = ~op[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dvs};
  assign take    = (rem_sh >= {1'b0, dvs});

  assign busy = (state != S_IDLE);

`ifdef MULDIV_ITER_MUL_EN
  logic           mul_mode;
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : '0);
`else
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && is_div && !b_zero) state_next = S_DIV;
`ifdef MULDIV_ITER_MUL_EN
        else if (start && is_mul)       state_next = S_MUL;
`endif
      end
      S_DIV:  if (cnt == CW'(1)) state_next = S_SIGN;
`ifdef MULDIV_ITER_MUL_EN
      S_MUL:  if (cnt == CW'(1)) state_next = S_SIGN;
`endif
      S_SIGN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      cnt  <= '0;
      dvs  <= '0;
      rem  <= '0;
      quo  <= '0;
      sq   <= 1'b0;
      sr   <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      mul_mode <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_mul) begin
`ifdef MULDIV_ITER_MUL_EN
              mul_mode <= 1'b1;
              dvs      <= a_mag;
              rem      <= '0;
              quo      <= b_mag;
              sq       <= a_neg ^ b_neg;
              sr       <= 1'b0;
              cnt      <= CW'(WIDTH);
`else
              {hi, lo} <= op[0] ? prod_u : prod_s;
              done     <= 1'b1;
`endif
            end else if (is_div) begin
              if (b_zero) begin
                lo   <= '1;
                hi   <= a;
                done <= 1'b1;
              end else begin
`ifdef MULDIV_ITER_MUL_EN
                mul_mode <= 1'b0;
`endif
                dvs <= b_mag;
                rem <= '0;
                quo <= a_mag;
                sq  <= a_neg ^ b_neg;
                sr  <= a_neg;
                cnt <= CW'(WIDTH);
              end
            end else if (op == 3'b100) begin
              hi <= a;
            end else if (op == 3'b101) begin
              lo <= a;
            end
          end
        end
        S_DIV: begin
          rem <= take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt - CW'(1);
        end
`ifdef MULDIV_ITER_MUL_EN
        S_MUL: begin
          // {rem,quo} holds the running product high half and the remaining multiplier bits
          rem <= mul_sum[WIDTH:1];
          quo <= {mul_sum[0], quo[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
        end
`endif
        S_SIGN: begin
`ifdef MULDIV_ITER_MUL_EN
          if (mul_mode) begin
            {hi, lo} <= sq ? -{rem, quo} : {rem, quo};
          end else begin
            lo <= sq ? -quo : quo;
            hi <= sr ? -rem : rem;
          end
`else
          lo <= sq ? -quo : quo;
          hi <= sr ? -rem : rem;
`endif
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
